// File: rtl/join_merge_arbiter.sv
// join_merge_arbiter
//   Merge point of the JOIN ring. Two sources compete for the single pipeline
//   entry. Source 0 is the external packet stream and source 1 is the
//   recirculated stream from the branch stage. The block presents one
//   registered packet per grant to the M stage.
//
//   The number of packets circulating in the ring is capped at RING_CAP.
//   Externals are the only way in, so recirculated traffic always finds room
//   and cannot deadlock. Internal traffic normally wins the entry. After
//   STARVE_LIMIT consecutive internal grants against a waiting, admissible
//   external packet, the external packet is forced through.
//
// Ports
//   CP, MR                  clock / async active-high reset
//   ex_send/ex_packet/ex_ack   external source handshake (ack = 1-cycle pulse)
//   in_send/in_packet/in_ack   internal source handshake (ack = 1-cycle pulse)
//   ring_exit               1-cycle pulse, one packet left the ring
//   out_send/out_packet/out_ack  registered output to the M stage
//   inflight, ring_full     registered ring occupancy
//   grant_int               source of the current/last capture (1 = internal)
//   cnt_err                 sticky: ring_exit seen while the ring was empty

// Per-source handshake slice.
// - The ack register pulses for the cycle after a grant.
// - While the ack is high the source is still showing the packet that was
//   just taken. That packet must not be taken twice, so eligibility waits for
//   the ack to drop.
module join_merge_arbiter_port (
  input  logic CP,
  input  logic MR,
  input  logic send,
  input  logic admit,     // extra admission gate (ring room for externals)
  input  logic grant,
  output logic eligible,
  output logic ack
);

  always_ff @(posedge CP or posedge MR) begin
    if (MR) ack <= 1'b0;
    else    ack <= grant;
  end

  assign eligible = send & ~ack & admit;

endmodule

module join_merge_arbiter #(
  parameter int PACKET_W     = 38,
  parameter int RING_CAP     = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                              CP,
  input  logic                              MR,
  input  logic                              ex_send,
  input  logic [PACKET_W-1:0]               ex_packet,
  output logic                              ex_ack,
  input  logic                              in_send,
  input  logic [PACKET_W-1:0]               in_packet,
  output logic                              in_ack,
  input  logic                              ring_exit,
  output logic                              out_send,
  output logic [PACKET_W-1:0]               out_packet,
  input  logic                              out_ack,
  output logic [$clog2(RING_CAP+1)-1:0]     inflight,
  output logic                              ring_full,
  output logic                              grant_int,
  output logic                              cnt_err
);

  localparam int NUM_SRC = 2;
  localparam int SRC_EXT = 0;
  localparam int SRC_INT = 1;
  localparam int CNT_W   = $clog2(RING_CAP + 1);
  localparam int STV_W   = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t state_q, state_d;

  logic [NUM_SRC-1:0]               src_send, src_admit, src_grant;
  logic [NUM_SRC-1:0]               src_elig, src_ack;
  logic [NUM_SRC-1:0][PACKET_W-1:0] src_packet;

  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic                ring_full_q, cnt_err_q, cnt_err_d;
  logic [STV_W-1:0]    starve_cnt;
  logic [PACKET_W-1:0] out_packet_q;
  logic                grant_int_q;

  logic starve_hit, pick_ext, cap_opp, capture;

  // Source slices
  assign src_send[SRC_EXT]   = ex_send;
  assign src_send[SRC_INT]   = in_send;
  assign src_packet[SRC_EXT] = ex_packet;
  assign src_packet[SRC_INT] = in_packet;
  // Only externals add to the ring, so only they are gated by occupancy.
  assign src_admit[SRC_EXT]  = (inflight_q < CNT_W'(RING_CAP));
  assign src_admit[SRC_INT]  = 1'b1;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    join_merge_arbiter_port u_port (
      .CP       (CP),
      .MR       (MR),
      .send     (src_send[g]),
      .admit    (src_admit[g]),
      .grant    (src_grant[g]),
      .eligible (src_elig[g]),
      .ack      (src_ack[g])
    );
  end

  assign ex_ack = src_ack[SRC_EXT];
  assign in_ack = src_ack[SRC_INT];

  // Arbitration
  // A full output slot can be refilled on the same edge it drains, so
  // alternating sources sustain one packet per cycle.
  assign starve_hit = (starve_cnt == STV_W'(STARVE_LIMIT));
  assign pick_ext   = src_elig[SRC_EXT] & (~src_elig[SRC_INT] | starve_hit);
  assign cap_opp    = (state_q == ST_EMPTY) | out_ack;
  assign capture    = cap_opp & (|src_elig);

  assign src_grant[SRC_EXT] = capture & pick_ext;
  assign src_grant[SRC_INT] = capture & ~pick_ext & src_elig[SRC_INT];

  // Output FSM: state register
  always_ff @(posedge CP or posedge MR) begin
    if (MR) state_q <= ST_EMPTY;
    else    state_q <= state_d;
  end

  // Output FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (capture) state_d = ST_FULL;
      ST_FULL:  if (out_ack && !capture) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Output FSM: outputs
  always_comb begin
    out_send = (state_q == ST_FULL);
  end

  // Output packet register. It holds its value across a drain, so it only
  // ever changes at a capture edge.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      out_packet_q <= '0;
      grant_int_q  <= 1'b0;
    end else if (capture) begin
      out_packet_q <= pick_ext ? src_packet[SRC_EXT] : src_packet[SRC_INT];
      grant_int_q  <= ~pick_ext;
    end
  end

  assign out_packet = out_packet_q;
  assign grant_int  = grant_int_q;

  // Ring occupancy
  // An external capture and an exit on the same edge cancel. An exit from an
  // empty ring is a bookkeeping fault: flag it and keep the count at 0.
  always_comb begin
    inflight_d = inflight_q;
    cnt_err_d  = cnt_err_q;
    case ({src_grant[SRC_EXT], ring_exit})
      2'b10: inflight_d = inflight_q + CNT_W'(1);
      2'b01: begin
        if (inflight_q == '0) cnt_err_d  = 1'b1;
        else                  inflight_d = inflight_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      inflight_q  <= '0;
      ring_full_q <= 1'b0;
      cnt_err_q   <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      ring_full_q <= (inflight_d == CNT_W'(RING_CAP));
      cnt_err_q   <= cnt_err_d;
    end
  end

  assign inflight  = inflight_q;
  assign ring_full = ring_full_q;
  assign cnt_err   = cnt_err_q;

  // Starvation counter
  // The count only advances while an external packet is actually admissible.
  // A packet held back only by a full ring is not starving.
  always_ff @(posedge CP or posedge MR) begin
    if (MR)
      starve_cnt <= '0;
    else if (src_grant[SRC_EXT] || !src_elig[SRC_EXT])
      starve_cnt <= '0;
    else if (src_grant[SRC_INT] && !starve_hit)
      starve_cnt <= starve_cnt + STV_W'(1);
  end

endmodule

// File: tb/tb_join_merge_arbiter.sv
module tb_join_merge_arbiter;

  localparam int PW = 38;
  localparam int RC = 2;
  localparam int SL = 4;
  localparam int CW = $clog2(RC + 1);

  logic          CP = 1'b0;
  logic          MR = 1'b1;
  logic          ex_send = 1'b0, in_send = 1'b0, ring_exit = 1'b0, out_ack = 1'b0;
  logic [PW-1:0] ex_packet = '0, in_packet = '0;
  logic          ex_ack, in_ack, out_send, ring_full, grant_int, cnt_err;
  logic [PW-1:0] out_packet;
  logic [CW-1:0] inflight;

  int checks = 0;
  int errors = 0;

  // Expected output stream: {grant_int, out_packet}
  logic [PW:0] sb_q[$];

  join_merge_arbiter #(.PACKET_W(PW), .RING_CAP(RC), .STARVE_LIMIT(SL)) dut (
    .CP(CP), .MR(MR),
    .ex_send(ex_send), .ex_packet(ex_packet), .ex_ack(ex_ack),
    .in_send(in_send), .in_packet(in_packet), .in_ack(in_ack),
    .ring_exit(ring_exit),
    .out_send(out_send), .out_packet(out_packet), .out_ack(out_ack),
    .inflight(inflight), .ring_full(ring_full),
    .grant_int(grant_int), .cnt_err(cnt_err)
  );

  always #5 CP = ~CP;

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CP);
    #1;
  endtask

  function automatic logic [PW-1:0] ext_pkt(input int i);
    return 38'h2A_C0DE_0000 + PW'(i);
  endfunction

  function automatic logic [PW-1:0] int_pkt(input int i);
    return 38'h15_BEEF_0000 + PW'(i);
  endfunction

  // A packet is consumed at the edge following a sample with out_send & out_ack
  always @(negedge CP) begin
    if (!MR && out_send && out_ack) begin
      logic [PW:0] e;
      chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_packet", 64'(out_packet), 64'(e[PW-1:0]));
        chk("sb_source", 64'(grant_int), 64'(e[PW]));
      end
    end
  end

  initial begin
    int ei, ii;
    logic want_ext;
    logic [PW-1:0] held;
    ei = 0; ii = 0;

    // Reset, then idle
    tick; tick;
    chk("rst_out_send",   64'(out_send),   64'd0);
    chk("rst_ex_ack",     64'(ex_ack),     64'd0);
    chk("rst_in_ack",     64'(in_ack),     64'd0);
    chk("rst_out_packet", 64'(out_packet), 64'd0);
    chk("rst_inflight",   64'(inflight),   64'd0);
    chk("rst_ring_full",  64'(ring_full),  64'd0);
    chk("rst_grant_int",  64'(grant_int),  64'd0);
    chk("rst_cnt_err",    64'(cnt_err),    64'd0);
    MR = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("idle_acks", 64'({ex_ack, in_ack, out_send}), 64'd0);
    end

    // Single external packet, out_ack high
    out_ack = 1'b1; ex_send = 1'b1; ex_packet = 38'h15_5555_5555;
    sb_q.push_back({1'b0, 38'h15_5555_5555});
    tick;
    chk("single_out_send", 64'(out_send), 64'd1);
    chk("single_ex_ack",   64'(ex_ack),   64'd1);
    chk("single_inflight", 64'(inflight), 64'd1);
    ex_send = 1'b0;
    tick;
    chk("single_drain",    64'({out_send, ex_ack}), 64'd0);
    chk("single_hold_pkt", 64'(out_packet), 64'h15_5555_5555);
    ring_exit = 1'b1;
    tick;
    ring_exit = 1'b0;
    chk("single_exit_inflight", 64'(inflight), 64'd0);
    chk("single_no_err",        64'(cnt_err),  64'd0);

    // Starvation: both sources held, downstream accepts every other cycle
    out_ack = 1'b0;
    ex_send = 1'b1; ex_packet = ext_pkt(ei);
    in_send = 1'b1; in_packet = int_pkt(ii);
    for (int k = 0; k < 10; k++) begin
      want_ext = (k % 5 == 4);
      sb_q.push_back(want_ext ? {1'b0, ext_pkt(ei)} : {1'b1, int_pkt(ii)});
      out_ack = (k > 0);
      tick;
      chk("starve_ex_ack",    64'(ex_ack),    64'(want_ext));
      chk("starve_in_ack",    64'(in_ack),    64'(!want_ext));
      chk("starve_grant_int", 64'(grant_int), 64'(!want_ext));
      if (ex_ack) begin ei++; ex_packet = ext_pkt(ei); end
      if (in_ack) begin ii++; in_packet = int_pkt(ii); end
      out_ack = 1'b0;
      tick;
    end
    chk("starve_inflight", 64'(inflight),  64'd2);
    chk("ring_full_set",   64'(ring_full), 64'd1);

    // Ring full: external blocked, internal still flows
    out_ack = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 0) sb_q.push_back({1'b1, int_pkt(ii)});
      tick;
      chk("full_ex_blocked", 64'(ex_ack), 64'd0);
      chk("full_in_ack",     64'(in_ack), 64'(j % 2 == 0));
      if (in_ack) begin ii++; in_packet = int_pkt(ii); end
    end
    in_send = 1'b0;
    chk("full_inflight", 64'(inflight), 64'd2);
    ring_exit = 1'b1;
    tick;
    ring_exit = 1'b0;
    chk("exit_inflight",  64'(inflight),  64'd1);
    chk("exit_not_full",  64'(ring_full), 64'd0);
    chk("exit_no_ack",    64'(ex_ack),    64'd0);
    sb_q.push_back({1'b0, ext_pkt(ei)});
    tick;
    chk("admit_ex_ack",   64'(ex_ack),    64'd1);
    chk("admit_inflight", 64'(inflight),  64'd2);
    chk("admit_full",     64'(ring_full), 64'd1);
    ei++;
    ex_send = 1'b0;
    tick;

    // Exit concurrent with external capture
    ring_exit = 1'b1;
    tick;
    chk("exit2_inflight", 64'(inflight), 64'd1);
    ex_send = 1'b1; ex_packet = ext_pkt(ei);
    sb_q.push_back({1'b0, ext_pkt(ei)});
    tick;
    chk("concurrent_ex_ack",   64'(ex_ack),   64'd1);
    chk("concurrent_inflight", 64'(inflight), 64'd1);
    ei++;
    ex_send = 1'b0; ring_exit = 1'b0;
    tick;

    // Exit underflow, sticky error
    ring_exit = 1'b1;
    tick;
    chk("drain_inflight", 64'(inflight), 64'd0);
    chk("drain_no_err",   64'(cnt_err),  64'd0);
    tick;
    ring_exit = 1'b0;
    chk("underflow_inflight", 64'(inflight), 64'd0);
    chk("underflow_err",      64'(cnt_err),  64'd1);
    tick; tick;
    chk("err_sticky", 64'(cnt_err), 64'd1);

    // Back-pressure
    out_ack = 1'b0;
    ex_send = 1'b1; ex_packet = ext_pkt(ei);
    in_send = 1'b1; in_packet = int_pkt(ii);
    held = int_pkt(ii);
    sb_q.push_back({1'b1, held});
    tick;
    chk("bp_first_in_ack", 64'(in_ack), 64'd1);
    ii++; in_packet = int_pkt(ii);
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("bp_hold_packet", 64'(out_packet), 64'(held));
      chk("bp_no_acks",     64'({ex_ack, in_ack}), 64'd0);
      chk("bp_out_send",    64'(out_send), 64'd1);
    end
    out_ack = 1'b1;
    sb_q.push_back({1'b1, int_pkt(ii)});
    tick;
    chk("bp_release_in_ack", 64'(in_ack),     64'd1);
    chk("bp_release_packet", 64'(out_packet), 64'(int_pkt(ii)));
    ii++;
    in_send = 1'b0;
    sb_q.push_back({1'b0, ext_pkt(ei)});
    tick;
    chk("bp_next_ex_ack", 64'(ex_ack), 64'd1);
    ei++;
    ex_send = 1'b0;
    tick;
    chk("bp_inflight", 64'(inflight), 64'd1);

    // Reset mid-transfer
    out_ack = 1'b0;
    ex_send = 1'b1; ex_packet = ext_pkt(ei);
    tick;
    chk("mr_pre_out_send", 64'(out_send), 64'd1);
    #3;
    MR = 1'b1; ex_send = 1'b0;
    #1;
    chk("mr_out_send",   64'(out_send),   64'd0);
    chk("mr_ex_ack",     64'(ex_ack),     64'd0);
    chk("mr_out_packet", 64'(out_packet), 64'd0);
    chk("mr_inflight",   64'(inflight),   64'd0);
    chk("mr_cnt_err",    64'(cnt_err),    64'd0);
    chk("mr_ring_full",  64'(ring_full),  64'd0);
    tick;
    MR = 1'b0;
    out_ack = 1'b1; ex_send = 1'b1;
    sb_q.push_back({1'b0, ext_pkt(ei)});
    tick;
    chk("mr_resend_ack",      64'(ex_ack),   64'd1);
    chk("mr_resend_inflight", 64'(inflight), 64'd1);
    ex_send = 1'b0;
    tick;
    tick;

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/join_merge_arbiter.md
# join_merge_arbiter

Clocked arbiter and admission controller for the merge point of the JOIN ring pipeline. It shares the single pipeline entry between the external packet stream and the internally recirculated packet stream from the branch stage. It limits the number of packets in flight inside the ring so that recirculation can never deadlock. It also bounds external starvation with a fairness counter, and presents one registered packet per grant to the M-stage input.

## Interface
Parameters:
- PACKET_W, 38, packet width in bits
- RING_CAP, 8, maximum packets in flight in the ring (1..255)
- STARVE_LIMIT, 4, consecutive internal grants tolerated while an admissible external packet waits (1..255)

Ports:
- CP  in  1  clock; all state updates on rising edge
- MR  in  1  reset, asynchronous, active-high
- ex_send  in  1  external packet valid; held until ex_ack seen
- ex_packet  in  PACKET_W  external packet, stable while ex_send high
- ex_ack  out  1  one-cycle pulse: external packet captured
- in_send  in  1  internal (recirculated) packet valid; held until in_ack seen
- in_packet  in  PACKET_W  internal packet
- in_ack  out  1  one-cycle pulse: internal packet captured
- ring_exit  in  1  one-cycle pulse: one packet has left the ring via the external branch
- out_send  out  1  output packet valid
- out_packet  out  PACKET_W  registered output packet
- out_ack  in  1  downstream accepted out_packet at this edge
- inflight  out  clog2(RING_CAP+1)  packets currently in the ring
- ring_full  out  1  inflight == RING_CAP
- grant_int  out  1  source of the current/last capture (1 = internal)
- cnt_err  out  1  sticky: ring_exit seen with inflight == 0

## Operation
- Output state machine: EMPTY (out_send=0) and FULL (out_send=1).
- Capture opportunity: the state is EMPTY, or the state is FULL with out_ack=1 at the same edge (back-to-back).
- Eligibility:
  - Internal: in_send=1 and in_ack currently low.
  - External: ex_send=1, ex_ack currently low, and inflight < RING_CAP.
- Priority: internal wins by default. External wins if only external is eligible, or if both are eligible and starve_cnt == STARVE_LIMIT.
- On capture:
  - out_packet is loaded with the winner's packet and the state moves to FULL.
  - The winner's ack pulses high for exactly the next cycle.
  - grant_int is updated.
- FULL with out_ack=1 and no eligible source: the state moves to EMPTY and out_packet holds its value.
- starve_cnt:
  - Cleared on an external grant.
  - Cleared when no external packet is eligible.
  - Incremented, saturating at STARVE_LIMIT, on an internal grant while an external packet is eligible.
  - A packet blocked only by ring_full does not count as eligible.
- inflight: +1 on an external capture, −1 on ring_exit; unchanged when both occur at the same edge.
- ring_exit with inflight == 0 and no external capture at that edge: inflight stays 0 and cnt_err is set.
- Internal captures do not change inflight.

## Timing
- Reset (MR=1, asynchronous):
  - out_send=0, ex_ack=0, in_ack=0, out_packet=0, inflight=0, ring_full=0, grant_int=0, cnt_err=0, starve_cnt=0, state EMPTY.
- MR asserted mid-transfer discards the held packet without acking it further. Sources must re-present their packets after MR falls.
- Latency: a source Send sampled at edge t yields out_send=1 and ack=1 during cycle t+1.
- Throughput: one packet per cycle across alternating sources; two cycles per packet from a single source, because of the ack-low eligibility rule.
- out_packet changes only at capture edges. It is stable while out_send=1 until the edge where out_ack is sampled.
- ring_full and inflight are registered and reflect counts after the edge.

## Test plan
- Reset then idle: assert MR mid-cycle. All outputs go to 0 immediately. No acks appear while ex_send=in_send=0.
- Single external packet 0x15_5555_5555 with out_ack tied high:
  - out_send=1 and ex_ack=1 in the cycle after ex_send is sampled.
  - inflight=1.
  - ring_exit pulse → inflight=0.
- Simultaneous sources, both held high, STARVE_LIMIT=4:
  - Grant order is I,I,I,I,E,I,I,I,I,E…
  - starve_cnt clears after each E.
- Ring capacity, RING_CAP=2:
  - Admit two external packets; ring_full=1. A third ex_send gets no ex_ack, while internal packets still pass.
  - One ring_exit pulse → the third packet is admitted next cycle.
- Back-pressure: hold out_ack=0 for 5 cycles with both sources pending. out_packet is unchanged and no ack pulses. Release → a new capture at the same edge as out_ack.
- Counter corner cases:
  - ring_exit with an external capture at the same edge: inflight is unchanged.
  - ring_exit at inflight=0: cnt_err=1 sticky until MR.
